// File: rtl/flag_branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : flag_branch_sequencer
//  Description : K2 program-flow sequencer. Owns the program counter, fetches
//                instructions over a req/valid handshake and resolves
//                J / JC / JZ / JNZ / HALT against the registered ALU flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_sequencer #(
  parameter int ADDR_BITS  = 4,
  parameter int INSTR_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  c_flag,
  input  logic                  z_flag,
  output logic                  instr_req,
  input  logic                  instr_valid,
  input  logic [INSTR_BITS-1:0] instr,
  output logic [ADDR_BITS-1:0]  pc,
  output logic [INSTR_BITS-1:0] exec_instr,
  output logic                  exec_valid,
  output logic                  taken,
  output logic                  halted
);

  // The opcode nibble sits above the jump target, so the word must hold both.
  generate
    if (INSTR_BITS < ADDR_BITS + 4) begin : g_width_check
      $error("INSTR_BITS must be at least ADDR_BITS+4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_JC   = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_JNZ  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [ADDR_BITS-1:0] PC_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [ADDR_BITS-1:0]    pc_q, pc_d;
  logic [INSTR_BITS-1:0]   exec_instr_q, exec_instr_d;

  logic [3:0]              opcode;
  logic [ADDR_BITS-1:0]    target;
  logic                    branch_hit;

  assign opcode     = exec_instr_q[INSTR_BITS-1 -: 4];
  assign target     = exec_instr_q[ADDR_BITS-1:0];
  assign pc         = pc_q;
  assign exec_instr = exec_instr_q;

  // Branch condition for the latched instruction; flags are used live, unregistered.
  always_comb begin
    branch_hit = 1'b0;
    case (opcode)
      OP_J:    branch_hit = 1'b1;
      OP_JC:   branch_hit = c_flag;
      OP_JZ:   branch_hit = z_flag;
      OP_JNZ:  branch_hit = ~z_flag;
      default: branch_hit = 1'b0;
    endcase
  end

  // Next-state, PC/instruction update and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    exec_instr_d = exec_instr_q;
    instr_req    = 1'b0;
    exec_valid   = 1'b0;
    taken        = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          exec_instr_d = instr;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_valid = 1'b1;
        if (opcode == OP_HALT) begin
          // PC is left on the HALT address so software can see where it stopped.
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          if (branch_hit) begin
            taken = 1'b1;
            pc_d  = target;
          end else begin
            pc_d  = pc_q + PC_ONE;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC and execute-instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      exec_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      exec_instr_q <= exec_instr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flag_branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flag_branch_sequencer
//  Description : Self-checking bench for flag_branch_sequencer: directed
//                sequences, a vector table and a randomized program run
//                checked against an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_branch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       c_flag = 1'b0;
  logic       z_flag = 1'b0;
  logic       instr_req;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic [3:0] pc;
  logic [7:0] exec_instr;
  logic       exec_valid;
  logic       taken;
  logic       halted;

  int n_tests = 0;
  int n_fail  = 0;

  flag_branch_sequencer #(.ADDR_BITS(4), .INSTR_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .c_flag      (c_flag),
    .z_flag      (z_flag),
    .instr_req   (instr_req),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .exec_instr  (exec_instr),
    .exec_valid  (exec_valid),
    .taken       (taken),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pre_pc;
    logic [7:0] ins;
    bit         c;
    bit         z;
    bit         exp_taken;
    logic [3:0] exp_pc;
    bit         exp_halt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; instr_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Serves one instruction from FETCH (after 'waits' empty cycles) through EXEC.
  task automatic exec_one(input logic [7:0] ins, input int waits, input bit c, input bit z,
                          input bit noise, output bit tk);
    logic [3:0] pc0;
    pc0 = pc;
    check("fetch_req", instr_req, 1);
    for (int i = 0; i < waits; i++) begin
      instr_valid = 1'b0;
      start = 1'($urandom_range(0, 1));
      tick();
      check("wait_req", instr_req, 1);
      check("wait_noexec", exec_valid, 0);
      check("wait_pc", pc, pc0);
    end
    start = 1'b0;
    instr = ins; instr_valid = 1'b1; c_flag = c; z_flag = z;
    tick();
    check("exec_valid", exec_valid, 1);
    check("exec_instr", exec_instr, ins);
    check("exec_noreq", instr_req, 0);
    tk = taken;
    if (noise) begin
      instr = ~ins; instr_valid = 1'b1;
    end else begin
      instr_valid = 1'b0;
    end
    tick();
    instr_valid = 1'b0;
    check("exec_pulse", exec_valid, 0);
    check("exec_hold", exec_instr, ins);
  endtask

  task automatic goto_pc(input logic [3:0] p);
    bit tk;
    exec_one({4'h8, p}, 0, 1'b0, 1'b0, 1'b0, tk);
    check("goto_pc", pc, p);
  endtask

  function automatic bit model_taken(input logic [3:0] op, input bit c, input bit z);
    case (op)
      4'h8:    return 1'b1;
      4'h9:    return c;
      4'hA:    return z;
      4'hB:    return !z;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[13];
    bit   tk;
    int   model_pc;
    int   exp_pc;
    bit   exp_tk;

    vecs[0]  = '{4'd2,  8'h97, 1, 0, 1, 4'd7,  0};
    vecs[1]  = '{4'd2,  8'h97, 0, 0, 0, 4'd3,  0};
    vecs[2]  = '{4'd5,  8'hA3, 0, 1, 1, 4'd3,  0};
    vecs[3]  = '{4'd5,  8'hA3, 0, 0, 0, 4'd6,  0};
    vecs[4]  = '{4'd6,  8'hB3, 0, 1, 0, 4'd7,  0};
    vecs[5]  = '{4'd6,  8'hB3, 1, 0, 1, 4'd3,  0};
    vecs[6]  = '{4'd15, 8'h40, 0, 0, 0, 4'd0,  0};
    vecs[7]  = '{4'd15, 8'h8F, 0, 0, 1, 4'd15, 0};
    vecs[8]  = '{4'd9,  8'h85, 1, 1, 1, 4'd5,  0};
    vecs[9]  = '{4'd4,  8'hF0, 1, 1, 0, 4'd4,  1};
    vecs[10] = '{4'd3,  8'h7A, 1, 1, 0, 4'd4,  0};
    vecs[11] = '{4'd15, 8'hC2, 0, 0, 0, 4'd0,  0};
    vecs[12] = '{4'd8,  8'h9E, 0, 1, 0, 4'd9,  0};

    // Reset in the middle of a fetch with a response arriving.
    reset_dut();
    start_run();
    goto_pc(4'd5);
    rst = 1'b1; instr = 8'h40; instr_valid = 1'b1;
    tick(); tick();
    rst = 1'b0; instr_valid = 1'b0;
    check("rst_pc", pc, 0);
    check("rst_req", instr_req, 0);
    check("rst_exec_valid", exec_valid, 0);
    check("rst_taken", taken, 0);
    check("rst_halted", halted, 0);
    check("rst_exec_instr", exec_instr, 0);

    // Reset beats a simultaneous start.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_idle", instr_req, 0);

    // instr_valid in IDLE is ignored.
    instr = 8'h55; instr_valid = 1'b1;
    tick(); tick();
    instr_valid = 1'b0;
    check("idle_no_latch", exec_instr, 0);
    check("idle_no_req", instr_req, 0);

    start_run();
    check("start_req", instr_req, 1);

    // Sequential non-branch fetches with two wait cycles each.
    for (int i = 0; i < 3; i++) begin
      exec_one(8'h40, 2, 1'b1, 1'b1, 1'b1, tk);
      check($sformatf("seq_taken%0d", i), tk, 0);
      check($sformatf("seq_pc%0d", i), pc, i + 1);
    end

    // Vector table: jump to pre_pc, execute, compare outcome.
    foreach (vecs[k]) begin
      reset_dut();
      start_run();
      goto_pc(vecs[k].pre_pc);
      exec_one(vecs[k].ins, k % 3, vecs[k].c, vecs[k].z, 1'b0, tk);
      check($sformatf("vec%0d_taken", k), tk, vecs[k].exp_taken);
      check($sformatf("vec%0d_pc", k), pc, vecs[k].exp_pc);
      check($sformatf("vec%0d_halt", k), halted, vecs[k].exp_halt);
    end

    // HALT at pc 4: sticky against start and instr_valid, cleared by reset.
    reset_dut();
    start_run();
    goto_pc(4'd4);
    exec_one(8'hF0, 0, 1'b0, 1'b0, 1'b0, tk);
    check("halt_taken", tk, 0);
    check("halt_flag", halted, 1);
    check("halt_pc", pc, 4);
    check("halt_noreq", instr_req, 0);
    for (int i = 0; i < 4; i++) begin
      start = 1'(i % 2); instr_valid = 1'(i / 2); instr = 8'h12;
      tick();
      check("halt_stuck", halted, 1);
      check("halt_pc_hold", pc, 4);
      check("halt_req_low", instr_req, 0);
      check("halt_instr_hold", exec_instr, 8'hF0);
    end
    start = 1'b0; instr_valid = 1'b0;
    reset_dut();
    check("halt_rst_pc", pc, 0);
    check("halt_rst_flag", halted, 0);

    // Randomized program against an instruction-level model.
    reset_dut();
    start_run();
    model_pc = 0;
    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      logic [7:0] ins;
      bit         c;
      bit         z;
      op  = 4'($urandom_range(0, 14));
      ins = {op, 4'($urandom)};
      c   = 1'($urandom);
      z   = 1'($urandom);
      exec_one(ins, int'($urandom_range(0, 3)), c, z, 1'($urandom), tk);
      exp_tk   = model_taken(op, c, z);
      exp_pc   = exp_tk ? int'(ins[3:0]) : (model_pc + 1) % 16;
      model_pc = exp_pc;
      check("rnd_taken", tk, exp_tk);
      check("rnd_pc", pc, exp_pc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
